// File: rtl/skein_unmix_engine.sv
// Threefish-256 inverse-round engine: undoes 1..8 forward MIX+permute rounds, one (or two) per clock.
// Optional SKEIN_UNMIX_DUAL_EN chains two inverse rounds per RUN cycle.
//
// state  | meaning
// S_IDLE | ready to accept a new state
// S_RUN  | applying inverse rounds, d counts down, cnt counts remaining rounds-1
// S_DONE | result held on out_state until out_ready
module skein_unmix_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_nrounds,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [255:0] r_v, w_v_nxt;
  logic [2:0]   r_d, w_d_nxt;
  logic [2:0]   r_cnt, w_cnt_nxt;
  logic [255:0] w_round1;
  logic [2:0]   w_d_m1;

  // Constant rotate-right by R(d,0); a plain 8:1 mux over fixed wirings.
  function automatic logic [63:0] rotr_p0(input logic [2:0] d, input logic [63:0] x);
    case (d)
      3'd0:    rotr_p0 = {x[13:0], x[63:14]};
      3'd1:    rotr_p0 = {x[51:0], x[63:52]};
      3'd2:    rotr_p0 = {x[22:0], x[63:23]};
      3'd3:    rotr_p0 = {x[4:0],  x[63:5]};
      3'd4:    rotr_p0 = {x[24:0], x[63:25]};
      3'd5:    rotr_p0 = {x[45:0], x[63:46]};
      3'd6:    rotr_p0 = {x[57:0], x[63:58]};
      default: rotr_p0 = {x[31:0], x[63:32]};
    endcase
  endfunction

  function automatic logic [63:0] rotr_p1(input logic [2:0] d, input logic [63:0] x);
    case (d)
      3'd0:    rotr_p1 = {x[15:0], x[63:16]};
      3'd1:    rotr_p1 = {x[56:0], x[63:57]};
      3'd2:    rotr_p1 = {x[39:0], x[63:40]};
      3'd3:    rotr_p1 = {x[36:0], x[63:37]};
      3'd4:    rotr_p1 = {x[32:0], x[63:33]};
      3'd5:    rotr_p1 = {x[11:0], x[63:12]};
      3'd6:    rotr_p1 = {x[21:0], x[63:22]};
      default: rotr_p1 = {x[31:0], x[63:32]};
    endcase
  endfunction

  function automatic logic [255:0] inv_round(input logic [2:0] d, input logic [255:0] v);
    logic [63:0] w0, w1, w2, w3, x0, x1, x2, x3;
    // un-permute: w = (v0, v3, v2, v1)
    w0 = v[63:0];
    w1 = v[255:192];
    w2 = v[191:128];
    w3 = v[127:64];
    x1 = rotr_p0(d, w1 ^ w0);
    x0 = w0 - x1;
    x3 = rotr_p1(d, w3 ^ w2);
    x2 = w2 - x3;
    inv_round = {x3, x2, x1, x0};
  endfunction

  assign w_round1 = inv_round(r_d, r_v);
  assign w_d_m1   = r_d - 3'd1;

`ifdef SKEIN_UNMIX_DUAL_EN
  logic [255:0] w_round2;
  assign w_round2 = inv_round(w_d_m1, w_round1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_v     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_v_nxt     = in_state;
          w_d_nxt     = in_rd;
          w_cnt_nxt   = in_nrounds;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
`ifdef SKEIN_UNMIX_DUAL_EN
        if (r_cnt == 3'd0) begin
          w_v_nxt     = w_round1;
          w_d_nxt     = w_d_m1;
          w_state_nxt = S_DONE;
        end else begin
          w_v_nxt = w_round2;
          w_d_nxt = r_d - 3'd2;
          // cnt==1 means exactly two rounds were left; both are done now
          if (r_cnt == 3'd1) begin
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - 3'd2;
          end
        end
`else
        w_v_nxt = w_round1;
        w_d_nxt = w_d_m1;
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
`endif
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_state = r_v;

endmodule

// File: tb/tb_skein_unmix_engine.sv
// Bench for skein_unmix_engine: plaintexts are pushed through a forward Threefish round model
// and the engine must recover them; a cycle-level handshake model is compared every cycle.
module tb_skein_unmix_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_state;
  logic [2:0]   in_rd;
  logic [2:0]   in_nrounds;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_state;

  skein_unmix_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_rd(in_rd), .in_nrounds(in_nrounds),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );

  always #5 clk = ~clk;

`ifdef SKEIN_UNMIX_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int RC0 [8] = '{14, 52, 23, 5, 25, 46, 58, 32};
  int RC1 [8] = '{16, 57, 40, 37, 33, 12, 22, 32};

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  // forward MIX on both pairs, then permute to (y0, y3, y2, y1)
  function automatic logic [255:0] fwd_round(input int d, input logic [255:0] s);
    logic [63:0] x0, x1, x2, x3, y0, y1, y2, y3;
    x0 = s[63:0]; x1 = s[127:64]; x2 = s[191:128]; x3 = s[255:192];
    y0 = x0 + x1; y1 = rotl64(x1, RC0[d]) ^ y0;
    y2 = x2 + x3; y3 = rotl64(x3, RC1[d]) ^ y2;
    return {y1, y2, y3, y0};
  endfunction

  // forward rounds rd-n .. rd (mod 8) in ascending order
  function automatic logic [255:0] fwd_chain(input int rd, input int n, input logic [255:0] p);
    logic [255:0] s;
    s = p;
    for (int k = n; k >= 0; k--) s = fwd_round((rd - k) & 7, s);
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int latency(input int n);
    return DUAL ? (n + 2) / 2 : n + 1;
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Handshake model: accept -> result after latency cycles -> held until out_ready.
  logic [255:0] tb_expect;
  logic [255:0] m_exp;
  bit           m_busy, m_valid;
  int           m_left;
  int           cyc = 0;
  int           last_acc = -1;
  bit           spacing_en = 0;
  bit           chk_en = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_left = 0;
    end else begin
      cyc++;
      if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_valid = 1; end
      end else if (in_valid) begin
        m_busy = 1;
        m_left = latency(int'(in_nrounds));
        m_exp  = tb_expect;
        if (spacing_en && last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != latency(7) + 2) begin
            n_fail++;
            $display("FAIL accept_spacing: got %0d want %0d", cyc - last_acc, latency(7) + 2);
          end
        end
        last_acc = spacing_en ? cyc : -1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      n_checks++;
      if (in_ready !== (!m_busy && !m_valid) || out_valid !== m_valid ||
          (m_valid && out_state !== m_exp)) begin
        n_fail++;
        $display("FAIL cycle_cmp @%0d: in_ready=%b out_valid=%b out_state=%h want in_ready=%b out_valid=%b out_state=%h",
                 cyc, in_ready, out_valid, out_state, !m_busy && !m_valid, m_valid, m_exp);
      end
    end
  end

  task automatic send(input logic [255:0] st, input int rd, input int n, input logic [255:0] exp);
    int t;
    in_state = st; in_rd = 3'(rd); in_nrounds = 3'(n); tb_expect = exp; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready stuck at %b want 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      t++;
      if (t > 100) begin
        n_checks++; n_fail++;
        $display("FAIL %s_timeout: out_valid stuck at %b want 1", nm, out_valid);
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((m_busy || m_valid) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: engine still busy, want idle", nm);
    end
  endtask

  initial begin
    logic [255:0] p;
    int rd, n, t;
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_rd = '0; in_nrounds = '0;
    out_ready = 1'b1; tb_expect = '0;
    #12;
    check("rst_in_ready",  256'(in_ready),  256'd1);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_out_state", out_state, 256'd0);
    #10 rst = 1'b0;
    chk_en = 1;

    check("model_fwd_d0",
          fwd_round(0, {64'd4, 64'd3, 64'd2, 64'd1}),
          {64'h8003, 64'd7, 64'h40007, 64'd3});
    check("model_fwd_borrow",
          fwd_round(0, {64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF}),
          {64'h4000, 64'd0, 64'd0, 64'd0});

    // single round, d=0
    @(posedge clk); #1;
    send({64'h8003, 64'd7, 64'h40007, 64'd3}, 0, 0, {64'd4, 64'd3, 64'd2, 64'd1});
    wait_valid("single");
    check("single_round", out_state, {64'd4, 64'd3, 64'd2, 64'd1});
    wait_idle("single");

    // borrow wrap
    @(posedge clk); #1;
    send({64'h4000, 64'd0, 64'd0, 64'd0}, 0, 0,
         {64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
    wait_valid("borrow");
    check("borrow_wrap", out_state, {64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
    wait_idle("borrow");

    // round-index wrap: forward rounds 6,7,0,1
    p = rand256();
    @(posedge clk); #1;
    send(fwd_chain(1, 3, p), 1, 3, p);
    wait_valid("dwrap");
    check("round_index_wrap", out_state, p);
    wait_idle("dwrap");

    // 1000 back-to-back full 8-round round trips
    @(posedge clk); #1;
    spacing_en = 1;
    for (int i = 0; i < 1000; i++) begin
      p  = rand256();
      rd = $urandom_range(0, 7);
      send(fwd_chain(rd, 7, p), rd, 7, p);
    end
    wait_idle("b2b");
    spacing_en = 0;

    // backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    p  = rand256();
    rd = $urandom_range(0, 7);
    @(posedge clk); #1;
    send(fwd_chain(rd, 5, p), rd, 5, p);
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_state = rand256();
    end
    in_valid = 1'b0;
    check("bp_held", out_state, p);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after", 256'(in_ready), 256'd1);

    // reset on the 3rd RUN cycle
    p  = rand256();
    rd = $urandom_range(0, 7);
    send(fwd_chain(rd, 7, p), rd, 7, p);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rst_run_valid", 256'(out_valid), 256'd0);
    check("rst_run_ready", 256'(in_ready), 256'd1);
    @(negedge clk); #2 rst = 1'b0;
    p  = rand256();
    rd = $urandom_range(0, 7);
    @(posedge clk); #1;
    send(fwd_chain(rd, 7, p), rd, 7, p);
    wait_valid("post_rst");
    check("post_rst_result", out_state, p);
    wait_idle("post_rst");

    // reset while DONE is held
    out_ready = 1'b0;
    p = rand256();
    @(posedge clk); #1;
    send(fwd_chain(2, 2, p), 2, 2, p);
    wait_valid("rst_done");
    #2 rst = 1'b1; #1;
    check("rst_done_valid", 256'(out_valid), 256'd0);
    check("rst_done_ready", 256'(in_ready), 256'd1);
    #4 rst = 1'b0;
    out_ready = 1'b1;

    // random round counts with random consumer stalls
    for (int i = 0; i < 150; i++) begin
      p  = rand256();
      rd = $urandom_range(0, 7);
      n  = $urandom_range(0, 7);
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      send(fwd_chain(rd, n, p), rd, n, p);
      t = 0;
      while ((m_busy || m_valid) && t < 100) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        t++;
      end
      if (t >= 100) begin
        n_checks++; n_fail++;
        $display("FAIL rand_timeout: op %0d never completed", i);
      end
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skein_unmix_engine.md
# skein_unmix_engine

Iterative Threefish-256 inverse-round engine for the decryption/verification path of the Skein core. It undoes up to eight forward MIX+permute rounds on a 256-bit state, one inverse round per clock. Each inverse round applies the inverse word permutation and then the inverse MIX on both word pairs. Subkey removal is outside this block; the key-schedule controller feeds it state between subkey subtractions.

## Interface
- Parameters: none.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state and control valid.
- in_ready  out  1  engine idle and able to accept.
- in_state  in  256  state words v0..v3, v0 at [63:0], v3 at [255:192].
- in_rd  in  3  round index (d mod 8) of the last forward round; the first inverse round uses it.
- in_nrounds  in  3  number of inverse rounds minus one (0 means 1 round, 7 means 8 rounds).
- out_valid  out  1  out_state holds the result.
- out_ready  in  1  consumer accepts the result.
- out_state  out  256  recovered state, same word packing as in_state.

## Operation
- Rotation constants are indexed by round d and pair j.
  - R(d,0) for d=0..7: 14,52,23,5,25,46,58,32.
  - R(d,1) for d=0..7: 16,57,40,37,33,12,22,32.
- One inverse round on v with index d:
  - Un-permute: w = (v0, v3, v2, v1).
  - Pair 0: x1 = rotr64(w1 ^ w0, R(d,0)), x0 = w0 - x1.
  - Pair 1: x3 = rotr64(w3 ^ w2, R(d,1)), x2 = w2 - x3.
  - All arithmetic is mod 2^64 and borrows are discarded.
  - Result: (x0, x1, x2, x3).
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, load the state register, d<=in_rd and cnt<=in_nrounds, then go to RUN.
  - RUN: each cycle, apply one inverse round with the current d, then d<=d-1 (mod 8, so 0 wraps to 7). If cnt==0, go to DONE; otherwise cnt<=cnt-1.
  - DONE: out_valid=1 and out_state is stable. When out_ready=1, go to IDLE.
- in_ready is asserted only in IDLE. Inputs are ignored in RUN and DONE.
- out_state is driven directly from the state register. Its value is only meaningful while out_valid=1.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, out_state=0, d=0, cnt=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. Nothing partial is ever presented; out_valid goes to 0 immediately (asynchronously).

## Timing
- Accept happens on the rising edge where in_valid & in_ready.
- out_valid rises exactly N cycles after the accept edge, where N = in_nrounds+1.
- out_valid is held for as long as out_ready=0.
- The output handshake edge returns the FSM to IDLE. in_ready is 1 in the following cycle.
- Minimum spacing between accepts is N+2 cycles, when out_ready is held at 1.
- Combinational path per cycle: one XOR, one 64-bit rotate mux (8:1), one 64-bit subtract. No input-to-output combinational path.

## Configuration
- SKEIN_UNMIX_DUAL_EN, when defined:
  - Two inverse rounds are chained per RUN cycle, using indices d and d-1. Then d<=d-2 and cnt<=cnt-2.
  - If cnt==0 at the start of a cycle, only one round is applied that cycle.
  - Latency becomes ceil(N/2) cycles.
- Without the macro: one round per cycle and latency N, as specified above.
- Handshake, reset behaviour and results are identical in both builds.

## Test plan
- Single round, d=0:
  - in_state = (3, 0x40007, 7, 0x8003), in_rd=0, in_nrounds=0.
  - Required: out_state = (1, 2, 3, 4); out_valid 1 cycle after accept (1 cycle in the dual build too).
- Borrow wrap: a forward round d=0 of (0xFFFFFFFFFFFFFFFF, 1, 0, 0) yields w0=0.
  - Feed the permuted forward result.
  - Required: out_state = (0xFFFFFFFFFFFFFFFF, 1, 0, 0).
- Round-index wrap: in_rd=1, in_nrounds=3, random state.
  - Required: the rounds use d=1,0,7,6, matching a bench reference model of forward rounds d=6,7,0,1.
  - Required: out_valid after 4 cycles (2 in the dual build).
- Full 8-round round-trip: 1000 random states, with in_rd random and in_nrounds=7.
  - Required: output equals the reference inverse every time.
  - Required: in_ready=0 throughout RUN and DONE, and back-to-back accept spacing of 10 cycles with out_ready held at 1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE.
  - Required: out_valid stays 1 and out_state stays stable; in_valid pulses are ignored.
  - Required: the handshake occurs on the first edge with out_ready=1, and in_ready=1 in the next cycle.
- Reset mid-RUN: assert rst on the 3rd cycle of an 8-round operation.
  - Required: out_valid=0 and in_ready=1 immediately.
  - Required: a new operation after reset produces the correct result.
